// File: rtl/control_multiciclo.sv
// control_multiciclo: multi-cycle control sequencer for a MIPS-32 datapath
// built around one shared ALU and a single memory for instructions and data.
// The opcode selects the path through the states, and each state drives a
// fixed control word. Memory states wait on mem_ready, with a timeout. An
// illegal opcode or a memory timeout locks the sequencer in FAULT until reset.
// Build option: define JUMP_EN to support J (opcode 000010). When it is not
// defined, J is treated as an illegal opcode.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | just out of reset, all controls off
// FETCH    | read instruction at PC, PC+4 on completion (waits mem_ready)
// DECODE   | precompute branch target, dispatch on opcode
// MEMADR   | effective address = A + sign-ext imm
// MEMRD    | data read at ALUOut (waits mem_ready)
// MEMWB    | register write from MDR into rt
// MEMWR    | data write at ALUOut (waits mem_ready)
// EXEC_R   | ALU on A,B under funct control
// RWB      | register write from ALUOut into rd
// EXEC_I   | ALU on A and sign-ext imm, op from opcode
// IWB      | register write from ALUOut into rt
// BRANCH   | compare A,B; load PC from ALUOut if zero
// JUMP     | load PC with jump target (JUMP_EN builds only)
// FAULT    | sticky trap, controls off, left only by reset
module control_multiciclo #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             PCWrite,
   output logic             PCWriteCond,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             MemtoReg,
   output logic             RegDst,
   output logic             RegWrite,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [2:0]       ALUOP,
   output logic [1:0]       PCSource,
   output logic             fault,
   output logic [CNT_W-1:0] instr_count
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_SLTI = 6'b001010;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_LWC1 = 6'b110001;

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
      S_EXEC_R, S_RWB, S_EXEC_I, S_IWB, S_BRANCH, S_FAULT
`ifdef JUMP_EN
      , S_JUMP
`endif
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [WAIT_W-1:0]   r_wait;
   logic [WAIT_W-1:0]   w_wait_next;
   logic                w_retire;
   logic                w_waiting;
   logic                w_timeout;
   logic                w_unused;

   // The zero flag only gates the PC load in the datapath; it is not needed here.
   assign w_unused = zero;

   assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
   // A cycle with mem_ready never times out, even when the counter is at its limit.
   assign w_timeout = w_waiting && !mem_ready && (r_wait == WAIT_W'(MEM_TIMEOUT - 1));
   assign fault     = (r_state == S_FAULT);

   // State, wait counter and retired-instruction counter registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_wait      <= '0;
         instr_count <= '0;
      end else begin
         r_state <= w_next;
         r_wait  <= w_wait_next;
         if (w_retire)
            instr_count <= instr_count + CNT_W'(1);
      end
   end

   // Next state, wait count and retire strobe.
   always_comb begin
      w_next      = r_state;
      w_retire    = 1'b0;
      // The counter is zero in every non-waiting state, so it is already clear
      // on entry to FETCH, MEMRD or MEMWR.
      w_wait_next = (w_waiting && !mem_ready) ? r_wait + WAIT_W'(1) : '0;
      case (r_state)
         S_IDLE:   w_next = S_FETCH;
         S_FETCH:  if (mem_ready) w_next = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_LWC1, OP_SW:             w_next = S_MEMADR;
               OP_R:                              w_next = S_EXEC_R;
               OP_BEQ:                            w_next = S_BRANCH;
               OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: w_next = S_EXEC_I;
`ifdef JUMP_EN
               OP_J:                              w_next = S_JUMP;
`else
               OP_J:                              w_next = S_FAULT;
`endif
               default:                           w_next = S_FAULT;
            endcase
         end
         S_MEMADR: w_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  if (mem_ready) w_next = S_MEMWB;
         S_MEMWR:  if (mem_ready) begin
            w_next   = S_FETCH;
            w_retire = 1'b1;
         end
         S_EXEC_R: w_next = S_RWB;
         S_EXEC_I: w_next = S_IWB;
         S_MEMWB, S_RWB, S_IWB, S_BRANCH: begin
            w_next   = S_FETCH;
            w_retire = 1'b1;
         end
`ifdef JUMP_EN
         S_JUMP: begin
            w_next   = S_FETCH;
            w_retire = 1'b1;
         end
`endif
         S_FAULT:  w_next = S_FAULT;
         default:  w_next = S_FAULT;
      endcase
      if (w_timeout) begin
         w_next      = S_FAULT;
         w_wait_next = '0;
      end
   end

   // Control word for each state. Only FETCH's IR and PC loads follow mem_ready.
   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUOP       = 3'b000;
      PCSource    = 2'b00;
      case (r_state)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
         end
         S_DECODE: ALUSrcB = 2'b11;
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         S_MEMWB: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
         end
         S_MEMWR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
         end
         S_EXEC_R: begin
            ALUSrcA = 1'b1;
            ALUOP   = 3'b010;
         end
         S_RWB: begin
            RegWrite = 1'b1;
            RegDst   = 1'b1;
         end
         S_EXEC_I: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            case (opcode)
               OP_SLTI: ALUOP = 3'b100;
               OP_ANDI: ALUOP = 3'b011;
               OP_ORI:  ALUOP = 3'b101;
               default: ALUOP = 3'b000;
            endcase
         end
         S_IWB: RegWrite = 1'b1;
         S_BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUOP       = 3'b001;
            PCWriteCond = 1'b1;
            PCSource    = 2'b01;
         end
`ifdef JUMP_EN
         S_JUMP: begin
            PCWrite  = 1'b1;
            PCSource = 2'b10;
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_multiciclo.sv
// Directed bench for control_multiciclo (MEM_TIMEOUT=4). The control outputs
// are packed into one 17-bit word so that each cycle can be compared against
// a hand-written constant for the expected state.
// Bit order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg
//            RegDst RegWrite ALUSrcA | ALUSrcB[1:0] | ALUOP[2:0] | PCSource[1:0]
module tb_control_multiciclo;

   localparam logic [16:0] CW_OFF    = 17'b0000000000_00_000_00;
   localparam logic [16:0] CW_FETCH  = 17'b1001010000_01_000_00;
   localparam logic [16:0] CW_FWAIT  = 17'b0001000000_01_000_00;
   localparam logic [16:0] CW_DECODE = 17'b0000000000_11_000_00;
   localparam logic [16:0] CW_MEMADR = 17'b0000000001_10_000_00;
   localparam logic [16:0] CW_MEMRD  = 17'b0011000000_00_000_00;
   localparam logic [16:0] CW_MEMWB  = 17'b0000001010_00_000_00;
   localparam logic [16:0] CW_MEMWR  = 17'b0010100000_00_000_00;
   localparam logic [16:0] CW_EXEC_R = 17'b0000000001_00_010_00;
   localparam logic [16:0] CW_RWB    = 17'b0000000110_00_000_00;
   localparam logic [16:0] CW_IWB    = 17'b0000000010_00_000_00;
   localparam logic [16:0] CW_BRANCH = 17'b0100000001_00_001_01;
   localparam logic [16:0] CW_JUMP   = 17'b1000000000_00_000_10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [5:0]  opcode = 6'b0;
   logic        zero = 1'b0;
   logic        mem_ready = 1'b1;
   logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic        MemtoReg, RegDst, RegWrite, ALUSrcA;
   logic [1:0]  ALUSrcB, PCSource;
   logic [2:0]  ALUOP;
   logic        fault;
   logic [31:0] instr_count;
   logic [16:0] cw;

   int n_checks = 0;
   int n_pass   = 0;

   control_multiciclo #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
      .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOP(ALUOP),
      .PCSource(PCSource), .fault(fault), .instr_count(instr_count)
   );

   assign cw = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOP, PCSource};

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Set mem_ready, check the current control word, then advance one clock.
   task automatic run(input string tag, input logic mr, input logic [16:0] exp_cw);
      mem_ready = mr;
      #1;
      chk(tag, {47'b0, cw}, {47'b0, exp_cw});
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      chk("rst_fault", {63'b0, fault}, 64'd0);
      chk("rst_count", {32'b0, instr_count}, 64'd0);
   endtask

   logic [5:0]  itype_op [4] = '{6'b001000, 6'b001010, 6'b001100, 6'b001101};
   logic [16:0] itype_cw [4] = '{17'b0000000001_10_000_00, 17'b0000000001_10_100_00,
                                 17'b0000000001_10_011_00, 17'b0000000001_10_101_00};

   initial begin
      mem_ready = 1'b1;
      @(posedge clk);
      do_reset();

      // R-type: IDLE, FETCH, DECODE, EXEC_R, RWB
      opcode = 6'b000000;
      run("r_idle",   1'b1, CW_OFF);
      run("r_fetch",  1'b1, CW_FETCH);
      run("r_decode", 1'b1, CW_DECODE);
      run("r_exec",   1'b1, CW_EXEC_R);
      run("r_wb",     1'b1, CW_RWB);
      chk("r_count", {32'b0, instr_count}, 64'd1);

      // LW with three not-ready cycles in MEMRD
      opcode = 6'b100011;
      run("lw_fetch",  1'b1, CW_FETCH);
      run("lw_decode", 1'b1, CW_DECODE);
      run("lw_adr",    1'b1, CW_MEMADR);
      run("lw_rd0",    1'b0, CW_MEMRD);
      run("lw_rd1",    1'b0, CW_MEMRD);
      run("lw_rd2",    1'b0, CW_MEMRD);
      run("lw_rd3",    1'b1, CW_MEMRD);
      run("lw_wb",     1'b1, CW_MEMWB);
      chk("lw_count", {32'b0, instr_count}, 64'd2);

      // LWC1 takes the same load path
      opcode = 6'b110001;
      run("lwc1_fetch", 1'b1, CW_FETCH);
      run("lwc1_dec",   1'b1, CW_DECODE);
      run("lwc1_adr",   1'b1, CW_MEMADR);
      run("lwc1_rd",    1'b1, CW_MEMRD);
      run("lwc1_wb",    1'b1, CW_MEMWB);

      // BEQ
      opcode = 6'b000100;
      run("beq_fetch",  1'b1, CW_FETCH);
      run("beq_decode", 1'b1, CW_DECODE);
      run("beq_branch", 1'b1, CW_BRANCH);
      chk("beq_count", {32'b0, instr_count}, 64'd4);

      // ADDI, SLTI, ANDI, ORI back to back
      for (int i = 0; i < 4; i++) begin
         opcode = itype_op[i];
         run("i_fetch",  1'b1, CW_FETCH);
         run("i_decode", 1'b1, CW_DECODE);
         run($sformatf("i_exec%0d", i), 1'b1, itype_cw[i]);
         run("i_wb",     1'b1, CW_IWB);
      end
      chk("i_count", {32'b0, instr_count}, 64'd8);

      // SW with a single not-ready cycle in MEMWR
      opcode = 6'b101011;
      run("sw_fetch",  1'b1, CW_FETCH);
      run("sw_decode", 1'b1, CW_DECODE);
      run("sw_adr",    1'b1, CW_MEMADR);
      run("sw_wr0",    1'b0, CW_MEMWR);
      run("sw_wr1",    1'b1, CW_MEMWR);
      chk("sw_count", {32'b0, instr_count}, 64'd9);

      // mem_ready arrives on the 4th FETCH cycle, then an illegal opcode traps
      opcode = 6'b111111;
      run("to_w0",    1'b0, CW_FWAIT);
      run("to_w1",    1'b0, CW_FWAIT);
      run("to_w2",    1'b0, CW_FWAIT);
      run("to_w3",    1'b1, CW_FETCH);
      run("ill_dec",  1'b1, CW_DECODE);
      chk("ill_fault", {63'b0, fault}, 64'd1);
      run("ill_off0", 1'b1, CW_OFF);
      run("ill_off1", 1'b0, CW_OFF);
      chk("ill_sticky", {63'b0, fault}, 64'd1);
      chk("ill_count", {32'b0, instr_count}, 64'd9);
      do_reset();
      run("ill_idle", 1'b1, CW_OFF);

      // mem_ready stuck low in FETCH: FAULT after four wait cycles
      run("tmo_w0", 1'b0, CW_FWAIT);
      run("tmo_w1", 1'b0, CW_FWAIT);
      run("tmo_w2", 1'b0, CW_FWAIT);
      run("tmo_w3", 1'b0, CW_FWAIT);
      chk("tmo_fault", {63'b0, fault}, 64'd1);
      run("tmo_off", 1'b1, CW_OFF);

      // Reset in the middle of a store: no write strobe after reset
      do_reset();
      opcode = 6'b101011;
      run("ab_idle",  1'b1, CW_OFF);
      run("ab_fetch", 1'b1, CW_FETCH);
      run("ab_dec",   1'b1, CW_DECODE);
      run("ab_adr",   1'b1, CW_MEMADR);
      mem_ready = 1'b0;
      do_reset();
      run("ab_idle2", 1'b0, CW_OFF);

      // Jump opcode
      opcode = 6'b000010;
      run("j_fetch",  1'b1, CW_FETCH);
      run("j_decode", 1'b1, CW_DECODE);
`ifdef JUMP_EN
      run("j_jump",   1'b1, CW_JUMP);
      chk("j_fault", {63'b0, fault}, 64'd0);
      chk("j_count", {32'b0, instr_count}, 64'd1);
`else
      chk("j_fault", {63'b0, fault}, 64'd1);
      chk("j_pcsrc", {62'b0, PCSource}, 64'd0);
      chk("j_count", {32'b0, instr_count}, 64'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
